unified_mem_arbiter: RTL

Shares one single-port backing memory between the fetch stage (instruction reads) and the memory stage (data reads and writes) of the pipelined Y86 core. The block arbitrates requests, sequences multi-cycle memory transactions with an ack handshake and a timeout, and returns read data, error status and stall signals to the pipeline control logic. It sits between the fetch and memory-stage logic and the shared RAM model.

---
 rtl/unified_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch and data stages; ARB_STATS_EN adds grant/conflict counters
module unified_mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ARB_STATS_EN
    output logic [31:0]       f_grants,
    output logic [31:0]       m_grants,
    output logic [31:0]       conflicts,
`endif
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_valid,
    output logic              f_error,
    output logic              F_stall,
    input  logic              m_req,
    input  logic              m_wr,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_valid,
    output logic              m_error,
    output logic              M_stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, F_BUSY, M_BUSY} state_t;

    state_t        state, state_n;
    logic [SW-1:0] starve;
    logic [TW-1:0] tcnt;
    logic          busy, done_ok, done_to, done, grant_f, grant_m, grant;

    always_comb begin
        busy    = state != IDLE;
        done_ok = busy & mem_ack;
        // an ack arriving on the very cycle the count hits the limit still wins
        done_to = busy & ~mem_ack & (tcnt == TLIM);
        done    = done_ok | done_to;
        grant_f = (state == IDLE) & f_req & (~m_req | (starve >= SLIM));
        grant_m = (state == IDLE) & m_req & ~grant_f;
        grant   = grant_f | grant_m;
        state_n = grant_f ? F_BUSY : grant_m ? M_BUSY : done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            starve    <= '0;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            f_valid   <= 1'b0;
            f_error   <= 1'b0;
            m_rdata   <= '0;
            m_valid   <= 1'b0;
            m_error   <= 1'b0;
        end else begin
            state   <= state_n;
            tcnt    <= (grant | ~busy | mem_ack) ? '0 : tcnt + 1'b1;
            starve  <= grant_f ? '0 : (grant_m & f_req & (starve != SLIM)) ? starve + 1'b1 : starve;
            f_valid <= (state == F_BUSY) & done;
            f_error <= (state == F_BUSY) & done_to;
            m_valid <= (state == M_BUSY) & done;
            m_error <= (state == M_BUSY) & done_to;
            if (grant) begin
                mem_req   <= 1'b1;
                mem_wr    <= grant_m & m_wr;
                mem_addr  <= grant_f ? f_addr : m_addr;
                mem_wdata <= grant_m ? m_wdata : '0;
            end else if (done) begin
                mem_req <= 1'b0;
                mem_wr  <= 1'b0;
            end
            if (state == F_BUSY && done)
                f_rdata <= done_ok ? mem_rdata : '0;
            // a successful write leaves the last read value in place
            if (state == M_BUSY && (done_to || (done_ok && !mem_wr)))
                m_rdata <= done_ok ? mem_rdata : '0;
        end
    end

    always_comb begin
        F_stall = f_req & ~f_valid;
        M_stall = m_req & ~m_valid;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            f_grants  <= '0;
            m_grants  <= '0;
            conflicts <= '0;
        end else begin
            if (state == F_BUSY && done_ok && f_grants != '1)
                f_grants <= f_grants + 1'b1;
            if (state == M_BUSY && done_ok && m_grants != '1)
                m_grants <= m_grants + 1'b1;
            if (state == IDLE && f_req && m_req && conflicts != '1)
                conflicts <= conflicts + 1'b1;
        end
    end
`endif
endmodule
